// File: rtl/dma_arb_pkg.sv
// Shared constants, FSM state encoding and channel decode helper for the
// DMA request arbiter.
package dma_arb_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_REQ   = 3'b010,
    ST_GRANT = 3'b100
  } arb_state_t;

  function automatic logic [3:0] onehot_ch(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational four-channel priority picker. Rotating mode aligns the request
// vector so highPtr sits at bit 0, finds the lowest set bit, then re-offsets.
module dma_priority_encoder (
  input  logic [3:0] effReq,
  input  logic [1:0] highPtr,
  input  logic       priorityType,
  output logic [1:0] winner,
  output logic       anyReq
);

  logic [1:0] base;
  logic [3:0] rot;
  logic [1:0] first;

  always_comb begin
    base = priorityType ? highPtr : 2'd0;
    // Shift-left by 4 yields zero, so base = 0 leaves the vector unrotated.
    rot = (effReq >> base) | (effReq << (3'd4 - {1'b0, base}));
    first = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) first = i[1:0];
    end
    winner = first + base;
    anyReq = |effReq;
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA request arbiter: merges/masks requests, picks a winner and
// runs the HRQ/HLDA hold sequence until timing-and-control reports completion.
module dma_priority_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] softwareReq,
  input  logic              controllerDisable,
  input  logic              priorityType,
  input  logic              HLDA,
  input  logic              assertDACK,
  input  logic              cycleDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [1:0]        activeCh,
  output arb_state_t        debugState
);

  // Hold handshake: HRQ is raised one cycle after a request appears and stays
  // high until the service ends; the grant is latched only in a cycle where
  // HRQ and HLDA are both high. HLDA falling while granted aborts the service.
  arb_state_t  state;
  logic [1:0]  high_ptr;
  logic [3:0]  eff_req;
  logic [1:0]  winner;
  logic        any_req;

  assign eff_req = controllerDisable ? 4'b0000 : ((DREQ & ~maskReg) | softwareReq);

  dma_priority_encoder u_enc (
    .effReq       (eff_req),
    .highPtr      (high_ptr),
    .priorityType (priorityType),
    .winner       (winner),
    .anyReq       (any_req)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      HRQ        <= 1'b0;
      grantValid <= 1'b0;
      activeCh   <= 2'd0;
      high_ptr   <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state <= ST_REQ;
            HRQ   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!any_req) begin
            state <= ST_IDLE;
            HRQ   <= 1'b0;
          end else if (HLDA) begin
            state      <= ST_GRANT;
            grantValid <= 1'b1;
            activeCh   <= winner;
          end
        end
        ST_GRANT: begin
          // Completion wins over a simultaneous HLDA drop, so rotation still happens.
          if (cycleDone || !HLDA) begin
            state      <= ST_IDLE;
            HRQ        <= 1'b0;
            grantValid <= 1'b0;
            activeCh   <= 2'd0;
            if (cycleDone && priorityType) high_ptr <= activeCh + 2'd1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          HRQ        <= 1'b0;
          grantValid <= 1'b0;
          activeCh   <= 2'd0;
        end
      endcase
    end
  end

  assign DACK = grantValid ? (onehot_ch(activeCh) & {NUM_CH{assertDACK}}) : '0;
  assign debugState = state;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: a behavioural hold/grant model is
// compared every cycle, plus literal checkpoints and a grant-order queue.
module tb_dma_priority_arbiter;
  import dma_arb_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ, maskReg, softwareReq;
  logic       controllerDisable, priorityType, HLDA, assertDACK, cycleDone;
  logic       HRQ, grantValid;
  logic [3:0] DACK;
  logic [1:0] activeCh;
  arb_state_t debugState;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg),
    .softwareReq(softwareReq), .controllerDisable(controllerDisable),
    .priorityType(priorityType), .HLDA(HLDA), .assertDACK(assertDACK),
    .cycleDone(cycleDone), .HRQ(HRQ), .DACK(DACK), .grantValid(grantValid),
    .activeCh(activeCh), .debugState(debugState)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  logic [3:0] m_eff;
  logic       m_hrq = 1'b0;
  logic       m_gv = 1'b0;
  int         m_ch = 0;
  int         m_ptr = 0;
  logic       m_started = 1'b0;

  assign m_eff = controllerDisable ? 4'b0000 : ((DREQ & ~maskReg) | softwareReq);

  function automatic int pick(input logic [3:0] req, input int base);
    for (int k = 0; k < 4; k++) begin
      if (req[(base + k) % 4]) return (base + k) % 4;
    end
    return 0;
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      m_hrq <= 1'b0; m_gv <= 1'b0; m_ch <= 0; m_ptr <= 0; m_started <= 1'b1;
    end else if (m_gv) begin
      if (cycleDone || !HLDA) begin
        m_gv <= 1'b0; m_hrq <= 1'b0; m_ch <= 0;
        if (cycleDone && priorityType) m_ptr <= (m_ch + 1) % 4;
      end
    end else if (m_hrq) begin
      if (m_eff == 4'b0000) m_hrq <= 1'b0;
      else if (HLDA) begin
        m_gv <= 1'b1;
        m_ch <= pick(m_eff, priorityType ? m_ptr : 0);
      end
    end else if (m_eff != 4'b0000) begin
      m_hrq <= 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare + grant-order scoreboard ----------------
  logic gv_d = 1'b0;
  logic [3:0] m_dack;
  logic [2:0] m_state;

  always @(negedge CLK) begin
    if (m_started) begin
      m_dack  = m_gv ? ((4'b0001 << m_ch) & {4{assertDACK}}) : 4'b0000;
      m_state = m_gv ? 3'b100 : (m_hrq ? 3'b010 : 3'b001);
      check("cyc_hrq", int'(HRQ), int'(m_hrq));
      check("cyc_grant_valid", int'(grantValid), int'(m_gv));
      check("cyc_active_ch", int'(activeCh), m_ch);
      check("cyc_dack", int'(DACK), int'(m_dack));
      check("cyc_state", int'(debugState), int'(m_state));
      if (grantValid && !gv_d && exp_q.size() > 0) begin
        check("grant_order", int'(activeCh), int'(exp_q.pop_front()));
      end
      gv_d <= grantValid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    DREQ = 4'b0000; maskReg = 4'b0000; softwareReq = 4'b0000;
    controllerDisable = 1'b0; priorityType = 1'b0; HLDA = 1'b0;
    assertDACK = 1'b1; cycleDone = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic wait_grant(input int budget);
    int n = 0;
    while (!grantValid && n < budget) begin
      step();
      n++;
    end
    if (!grantValid) begin
      checks++;
      errors++;
      $display("FAIL wait_grant: no grant within %0d cycles", budget);
    end
  endtask

  task automatic serve();
    cycleDone = 1'b1;
    step();
    cycleDone = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    clear_inputs();
    RESET = 1'b1; DREQ = 4'b1111; HLDA = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_hrq", int'(HRQ), 0);
      check("reset_dack", int'(DACK), 0);
      check("reset_gv", int'(grantValid), 0);
    end
    RESET = 1'b0;
    step();
    check("reset_release_hrq", int'(HRQ), 1);
    check("reset_release_gv", int'(grantValid), 0);
    step();
    check("reset_first_grant", int'(grantValid), 1);

    // Fixed priority
    do_reset();
    DREQ = 4'b0011; HLDA = 1'b1;
    step();
    check("fix_hrq", int'(HRQ), 1);
    step();
    check("fix_gv", int'(grantValid), 1);
    check("fix_ch", int'(activeCh), 0);
    check("fix_dack", int'(DACK), 1);
    assertDACK = 1'b0;
    #1;
    check("fix_dack_gated", int'(DACK), 0);
    assertDACK = 1'b1;
    serve();
    check("fix_gap_hrq", int'(HRQ), 0);
    check("fix_gap_dack", int'(DACK), 0);
    step();
    check("fix_rehrq", int'(HRQ), 1);
    step();
    check("fix_second_ch", int'(activeCh), 0);
    serve();
    DREQ = 4'b0000;
    step();

    // Rotating priority
    do_reset();
    priorityType = 1'b1; DREQ = 4'b1111; HLDA = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    for (int g = 0; g < 5; g++) begin
      wait_grant(10);
      serve();
      check("rot_gap_hrq", int'(HRQ), 0);
    end
    DREQ = 4'b0000;
    step();

    // Mask and software request
    do_reset();
    maskReg = 4'b0001; DREQ = 4'b0001; HLDA = 1'b1;
    step(); step(); step();
    check("mask_no_hrq", int'(HRQ), 0);
    softwareReq = 4'b0001;
    step();
    check("swreq_hrq", int'(HRQ), 1);
    step();
    check("swreq_ch", int'(activeCh), 0);
    check("swreq_gv", int'(grantValid), 1);
    serve();
    softwareReq = 4'b0000;
    step();

    // Request withdrawn before HLDA
    do_reset();
    DREQ = 4'b0100;
    step();
    check("pulse_hrq", int'(HRQ), 1);
    DREQ = 4'b0000;
    step();
    check("pulse_withdraw", int'(HRQ), 0);
    HLDA = 1'b1;
    step();
    check("pulse_no_grant", int'(grantValid), 0);

    // HLDA loss aborts without rotation; cycleDone beats HLDA loss
    do_reset();
    priorityType = 1'b1; DREQ = 4'b1111; HLDA = 1'b1;
    wait_grant(10);
    check("abort_first_ch", int'(activeCh), 0);
    HLDA = 1'b0;
    step();
    check("abort_gv", int'(grantValid), 0);
    check("abort_hrq", int'(HRQ), 0);
    HLDA = 1'b1;
    wait_grant(10);
    check("abort_no_rot", int'(activeCh), 0);
    cycleDone = 1'b1; HLDA = 1'b0;
    step();
    cycleDone = 1'b0; HLDA = 1'b1;
    wait_grant(10);
    check("done_beats_hlda", int'(activeCh), 1);
    serve();
    DREQ = 4'b0000;
    step();

    // Controller disable
    do_reset();
    controllerDisable = 1'b1; DREQ = 4'b0100; HLDA = 1'b1;
    step(); step(); step();
    check("dis_no_hrq", int'(HRQ), 0);
    controllerDisable = 1'b0;
    step();
    check("dis_release_hrq", int'(HRQ), 1);
    step();
    check("dis_grant_ch", int'(activeCh), 2);
    controllerDisable = 1'b1;
    step(); step();
    check("dis_no_cut", int'(grantValid), 1);
    serve();
    step(); step(); step();
    check("dis_no_rehrq", int'(HRQ), 0);

    check("grant_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
